hann_buf_reader: RTL
====================

Name: hann_buf_reader

Overview:
- Read-side engine for the Hann-to-FFT sample buffer (4096 x 16-bit, synchronous read).
- On a start pulse, it reads one frame of FRAME_LEN consecutive windowed samples beginning at a given base address, wrapping modulo 2^ADDR_W.
- It streams the samples to the FFT input as a valid/ready stream with start-of-frame and end-of-frame markers.
- An internal skid FIFO absorbs the RAM read latency so downstream backpressure never drops or duplicates a sample.

Parameters:
- ADDR_W, 12, buffer address width; address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 16, sample width.
- FRAME_LEN, 1024, samples per frame; legal range 1..2^ADDR_W.
- RD_LAT, 1, buffer read latency in cycles; data for the address presented in cycle t is valid in cycle t+RD_LAT.
- FIFO_DEPTH, 4, skid FIFO entries; must be >= RD_LAT+2.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- base_addr  in  ADDR_W  first sample address; sampled on an accepted start.
- mem_addr  out  ADDR_W  buffer read address.
- mem_data  in  DATA_W  buffer read data, RD_LAT cycles after mem_addr.
- out_data  out  DATA_W  sample to FFT.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  FFT accepts the sample; transfer occurs when out_valid and out_ready are both high.
- out_sop  out  1  high with the first sample of a frame.
- out_eop  out  1  high with sample FRAME_LEN-1 of a frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the eop transfer.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; all state clears immediately on assertion.
- Reset values: mem_addr=0, out_valid=0, out_sop=0, out_eop=0, busy=0, done=0; FIFO empty; counters 0; state IDLE.
- State machine IDLE / READ / DRAIN:
  - IDLE: start=1 latches rd_ptr=base_addr, issue_cnt=0, sent_cnt=0, sets busy=1 and goes to READ. start is ignored in READ and DRAIN.
  - READ: issues a read in any cycle where issue_cnt<FRAME_LEN and (FIFO occupancy + reads in flight) < FIFO_DEPTH. Each issue drives mem_addr=rd_ptr, then rd_ptr+1 (wraps 2^ADDR_W-1 -> 0) and issue_cnt+1. When issue_cnt reaches FRAME_LEN, go to DRAIN.
  - DRAIN: no further issues. Waits until sent_cnt==FRAME_LEN, then pulses done for 1 cycle, clears busy and returns to IDLE in the same cycle.
- Read pipeline: a shift register of RD_LAT valid bits tracks in-flight reads. When a bit emerges, mem_data is pushed into the FIFO. Credit accounting guarantees the FIFO never overflows; an overflow is a design error and should be flagged by an assertion.
- Output stream:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - On a transfer: pop the head and increment sent_cnt.
  - out_sop = out_valid and sent_cnt==0; out_eop = out_valid and sent_cnt==FRAME_LEN-1.
  - While out_valid=1 and out_ready=0, out_data, out_sop and out_eop are held stable.
- Latency: with out_ready held at 1, the first mem_addr is driven 1 cycle after start, and the first out_valid appears RD_LAT+1 cycles after that. Steady-state throughput is 1 sample/cycle.
- mem_addr holds its last value when not issuing; the buffer may be read harmlessly.
- Simultaneous events:
  - FIFO push and pop in the same cycle: occupancy unchanged.
  - start in the same cycle as done: start is ignored; the next frame needs a start pulse in IDLE, at the earliest the cycle after done.
- FRAME_LEN=1: sop and eop are both high on the single sample.
- Reset mid-frame aborts the frame immediately: FIFO flushed, out_valid drops with no eop and no done, and in-flight read data is discarded.

Test Plan:
- FRAME_LEN=8, buffer word[i]=i+100, base=0, out_ready=1 -> 8 transfers carrying 100..107 on consecutive cycles; sop on 100, eop on 107; done pulses once; busy high from the cycle after start until done.
- FRAME_LEN=8, base=4093 -> mem_addr sequence 4093,4094,4095,0,1,2,3,4; output data matches those words in order.
- FRAME_LEN=16, out_ready pseudo-random (~40% high) -> exactly 16 transfers, in order, no duplicates; data/sop/eop stable during stalls; FIFO occupancy never exceeds FIFO_DEPTH.
- A second start pulse issued mid-frame and another coincident with done -> both ignored; exactly one frame emitted; a start the cycle after done launches a new frame.
- reset asserted after 3 of 8 transfers -> all outputs at reset values within the same cycle; no done; a fresh start then emits a full, correct 8-sample frame.
- FRAME_LEN=1, RD_LAT=2, FIFO_DEPTH=4 -> one transfer with sop=eop=1; first out_valid 3 cycles after the first mem_addr is driven.

Source files
------------

// File: rtl/hann_buf_reader.sv
// Read-side engine for the Hann-to-FFT sample buffer: fetches one frame of
// consecutive samples and streams them out with sop/eop through a skid FIFO.
module hann_buf_reader #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy,
  output logic              done
);
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] last_addr;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  sent_cnt;
  logic [RD_LAT-1:0] inflight;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_head;
  logic [PTR_W-1:0]  fifo_tail;
  logic [OCC_W-1:0]  fifo_cnt;
  logic [LVL_W-1:0]  level;
  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push      = inflight[RD_LAT-1];
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_mem[fifo_head];
  assign out_sop   = out_valid && (sent_cnt == '0);
  assign out_eop   = out_valid && (sent_cnt == LAST_CNT);
  assign busy      = (state != IDLE);
  // Reads in flight are credited against the FIFO so every return has a slot.
  assign level     = LVL_W'(fifo_cnt) + LVL_W'($countones(inflight));
  assign mem_addr  = issue ? rd_ptr : last_addr;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        if (issue_cnt < FULL_CNT && level < LVL_W'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (issue_cnt == LAST_CNT) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (sent_cnt == FULL_CNT) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      last_addr <= '0;
      issue_cnt <= '0;
      sent_cnt  <= '0;
      inflight  <= '0;
      fifo_head <= '0;
      fifo_tail <= '0;
      fifo_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= RD_LAT'({inflight, issue});
      if (accept) begin
        rd_ptr    <= base_addr;
        issue_cnt <= '0;
        sent_cnt  <= '0;
      end else begin
        if (issue) begin
          rd_ptr    <= rd_ptr + 1'b1;
          issue_cnt <= issue_cnt + 1'b1;
          last_addr <= rd_ptr;
        end
        if (pop) sent_cnt <= sent_cnt + 1'b1;
      end
      if (push) fifo_tail <= ptr_inc(fifo_tail);
      if (pop)  fifo_head <= ptr_inc(fifo_head);
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_tail] <= mem_data;
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && fifo_cnt == OCC_W'(FIFO_DEPTH)));

endmodule
